// File: rtl/qos_pkg.sv
// Shared definitions for the QoS egress path.
// Class codes, state encoding and sizing constants.
package qos_pkg;

    localparam int NUM_CLASSES = 4;
    localparam int WORD_W      = 12;

    localparam logic [1:0] CLS_P0 = 2'b00;
    localparam logic [1:0] CLS_P1 = 2'b01;
    localparam logic [1:0] CLS_P2 = 2'b10;
    localparam logic [1:0] CLS_P3 = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } qos_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req at start+1, start+2, ... wrapping,
// with start itself checked last. Ports: req, start in; idx, any_valid out.
module rr_pick
    import qos_pkg::*;
(
    input  logic [NUM_CLASSES-1:0] req,
    input  logic [1:0]             start,
    output logic [1:0]             idx,
    output logic                   any_valid
);

    logic [1:0] cand;

    // Walk from farthest to nearest so the nearest request wins.
    always_comb begin
        idx       = start;
        any_valid = 1'b0;
        cand      = start;
        for (int i = 4; i >= 1; i--) begin
            cand = start + 2'(i);
            if (req[cand]) begin
                idx       = cand;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qos_egress_arbiter.sv
// Weighted round-robin drain of four class FIFOs into one output FIFO.
// Ports: clk, reset, active, empty[3:0], fifo_data0..3, almost_full_out in;
// pop[3:0], push, data_out out. Pop-to-push latency is two cycles.
module qos_egress_arbiter
    import qos_pkg::*;
#(
    parameter int WORD_W = qos_pkg::WORD_W,
    parameter int W0     = 4,
    parameter int W1     = 3,
    parameter int W2     = 2,
    parameter int W3     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   active,
    input  logic [NUM_CLASSES-1:0] empty,
    input  logic [WORD_W-1:0]      fifo_data0,
    input  logic [WORD_W-1:0]      fifo_data1,
    input  logic [WORD_W-1:0]      fifo_data2,
    input  logic [WORD_W-1:0]      fifo_data3,
    input  logic                   almost_full_out,
    output logic [NUM_CLASSES-1:0] pop,
    output logic                   push,
    output logic [WORD_W-1:0]      data_out
);

    qos_state_e  state;
    logic [1:0]  cur;
    logic [3:0]  credit;
    logic [1:0]  pop_sel;
    logic        vld1;
    logic [1:0]  sel1;

    logic [NUM_CLASSES-1:0] req;
    logic [1:0]  pick_idx;
    logic        pick_any;

    logic        gnt;
    logic [1:0]  gnt_idx;
    logic [1:0]  nxt_cur;
    logic [3:0]  nxt_credit;
    logic [WORD_W-1:0] word_mux;

    function automatic logic [3:0] weight(input logic [1:0] k);
        unique case (k)
            CLS_P0: return 4'(W0);
            CLS_P1: return 4'(W1);
            CLS_P2: return 4'(W2);
            CLS_P3: return 4'(W3);
        endcase
    endfunction

    assign req = ~empty;

    rr_pick u_pick (
        .req       (req),
        .start     (cur),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    // The picker checks cur last, so a lone nonempty cur with no credit
    // lands in the second branch and reloads its own weight.
    always_comb begin
        gnt        = 1'b0;
        gnt_idx    = cur;
        nxt_cur    = cur;
        nxt_credit = credit;
        if (active && !almost_full_out) begin
            if (!empty[cur] && credit != 4'd0) begin
                gnt        = 1'b1;
                nxt_credit = credit - 4'd1;
            end else if (pick_any) begin
                gnt        = 1'b1;
                gnt_idx    = pick_idx;
                nxt_cur    = pick_idx;
                nxt_credit = weight(pick_idx) - 4'd1;
            end
        end
    end

    always_comb begin
        word_mux = fifo_data0;
        unique case (sel1)
            CLS_P0: word_mux = fifo_data0;
            CLS_P1: word_mux = fifo_data1;
            CLS_P2: word_mux = fifo_data2;
            CLS_P3: word_mux = fifo_data3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cur      <= CLS_P0;
            credit   <= 4'(W0);
            pop      <= '0;
            pop_sel  <= CLS_P0;
            vld1     <= 1'b0;
            sel1     <= CLS_P0;
            push     <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= gnt ? ST_SERVE : ST_IDLE;
            cur      <= nxt_cur;
            credit   <= nxt_credit;
            pop      <= gnt ? (4'b0001 << gnt_idx) : '0;
            pop_sel  <= gnt_idx;
            // FIFO data for a SERVE cycle arrives one cycle later.
            vld1     <= (state == ST_SERVE);
            sel1     <= pop_sel;
            push     <= vld1;
            if (vld1) begin
                data_out <= word_mux;
            end
        end
    end

endmodule

// File: tb/tb_qos_egress_arbiter.sv
// Randomized and directed bench for qos_egress_arbiter with a queue-based
// model of the class FIFOs and of the weighted round-robin schedule.
module tb_qos_egress_arbiter;

    localparam int WW = 12;

    int W [4] = '{4, 3, 2, 1};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          active = 1'b1;
    logic          af = 1'b0;
    logic [3:0]    empty = 4'hF;
    logic [WW-1:0] fd [4];
    logic [3:0]    pop;
    logic          push;
    logic [WW-1:0] data_out;

    int checks = 0;
    int failures = 0;

    logic [WW-1:0] q [4][$];
    int cur_m = 0;
    int run_m = 0;

    logic          pp_v = 1'b0;
    int            pp_k = 0;
    logic [WW-1:0] pp_w = '0;
    logic          s1_v = 1'b0;
    logic [WW-1:0] s1_w = '0;
    logic          exp_push = 1'b0;
    logic [WW-1:0] exp_dout = '0;

    int            pop_log [$];
    int            pop_cyc [$];
    logic [WW-1:0] push_log [$];
    int            push_cyc [$];
    int cyc = 0;
    int pushed = 0;

    always #5 clk = ~clk;

    qos_egress_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .active          (active),
        .empty           (empty),
        .fifo_data0      (fd[0]),
        .fifo_data1      (fd[1]),
        .fifo_data2      (fd[2]),
        .fifo_data3      (fd[3]),
        .almost_full_out (af),
        .pop             (pop),
        .push            (push),
        .data_out        (data_out)
    );

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, a, e);
        end
    endtask

    function automatic logic [WW-1:0] mk(input int k);
        logic [9:0] lo;
        lo = 10'($urandom);
        if ($urandom_range(0, 7) == 0) lo = '0;
        return {2'(k), lo};
    endfunction

    // Schedule rule: stay on cur for up to W[cur] consecutive grants,
    // otherwise take the next nonempty class after cur (cur itself last).
    task automatic model_step(output logic [3:0] g);
        int k;
        g = '0;
        if (reset) begin
            cur_m = 0;
            run_m = 0;
        end else if (active && !af) begin
            if (q[cur_m].size() > 0 && run_m < W[cur_m]) begin
                g = 4'(1 << cur_m);
                run_m++;
            end else begin
                for (int i = 1; i <= 4; i++) begin
                    k = (cur_m + i) % 4;
                    if (q[k].size() > 0) begin
                        cur_m = k;
                        run_m = 1;
                        g = 4'(1 << k);
                        break;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        logic [3:0] g;
        logic rst_at;
        for (int k = 0; k < 4; k++) empty[k] = (q[k].size() == 0);
        model_step(g);
        rst_at = reset;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 4; k++) fd[k] = WW'($urandom);
        if (pp_v) fd[pp_k] = pp_w;
        if (rst_at) begin
            exp_push = 1'b0;
            exp_dout = '0;
            s1_v = 1'b0;
        end else begin
            exp_push = s1_v;
            if (s1_v) exp_dout = s1_w;
            s1_v = pp_v;
            s1_w = pp_w;
        end
        chk("pop", 32'(pop), 32'(g));
        chk("push", 32'(push), 32'(exp_push));
        if (exp_push || rst_at) chk("data_out", 32'(data_out), 32'(exp_dout));
        if (push === 1'b1) begin
            push_log.push_back(data_out);
            push_cyc.push_back(cyc);
            pushed++;
        end
        pp_v = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (pop[k] === 1'b1 && !pp_v) begin
                pp_v = 1'b1;
                pp_k = k;
            end
        end
        if (pp_v) begin
            pp_w = '0;
            if (q[pp_k].size() > 0) pp_w = q[pp_k].pop_front();
            pop_log.push_back(pp_k);
            pop_cyc.push_back(cyc);
        end
    endtask

    task automatic clear_logs();
        pop_log.delete();
        pop_cyc.delete();
        push_log.delete();
        push_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        active = 1'b1;
        af = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 4; k++) q[k].delete();
        tick();
    endtask

    int e2 [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    int e3 [7]  = '{0, 0, 2, 2, 2, 2, 2};
    int e5 [5]  = '{3, 1, 1, 1, 0};
    int base;

    initial begin
        for (int k = 0; k < 4; k++) fd[k] = '0;

        // Reset held with every class nonempty
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 30; i++) q[k].push_back(mk(k));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_pop", 32'(pop), 0);
            chk("rst_push", 32'(push), 0);
            chk("rst_dout", 32'(data_out), 0);
        end
        reset = 1'b0;
        clear_logs();
        tick();
        chk("first_pop", 32'(pop), 32'h1);

        // Weighted sequence with all classes backlogged
        for (int i = 0; i < 24; i++) tick();
        chk("wrr_len_ok", 32'(pop_log.size() >= 20), 1);
        if (pop_log.size() >= 20)
            for (int i = 0; i < 20; i++)
                chk("wrr_seq", 32'(pop_log[i]), 32'(e2[i % 10]));

        // Class 0 empties mid-burst, class 2 takes over without a bubble
        do_reset();
        for (int i = 0; i < 2; i++) q[0].push_back(mk(0));
        for (int i = 0; i < 5; i++) q[2].push_back(mk(2));
        reset = 1'b0;
        clear_logs();
        for (int i = 0; i < 12; i++) tick();
        chk("mid_pop_cnt", 32'(pop_log.size()), 7);
        chk("mid_push_cnt", 32'(push_log.size()), 7);
        if (pop_log.size() == 7 && push_log.size() == 7) begin
            for (int i = 0; i < 7; i++) begin
                chk("mid_pop_seq", 32'(pop_log[i]), 32'(e3[i]));
                chk("mid_pop_gap", 32'(pop_cyc[i]), 32'(pop_cyc[0] + i));
                chk("mid_push_cls", 32'(push_log[i][11:10]), 32'(e3[i]));
                chk("mid_push_gap", 32'(push_cyc[i]), 32'(pop_cyc[0] + 2 + i));
            end
        end

        // Backpressure with two words in flight
        do_reset();
        for (int i = 0; i < 6; i++) q[0].push_back(mk(0));
        for (int i = 0; i < 6; i++) q[1].push_back(mk(1));
        reset = 1'b0;
        base = pushed;
        tick();
        tick();
        af = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_pop", 32'(pop), 0);
        end
        chk("bp_inflight", 32'(pushed - base), 2);
        af = 1'b0;
        tick();
        chk("bp_resume", 32'(pop != 0), 1);
        for (int i = 0; i < 20; i++) tick();
        chk("bp_total", 32'(pushed - base), 12);

        // Wrap from class 3 and pause with active low
        do_reset();
        q[3].push_back(mk(3));
        reset = 1'b0;
        clear_logs();
        base = pushed;
        tick();
        chk("wrap_p3", 32'(pop), 32'h8);
        for (int i = 0; i < 5; i++) q[1].push_back(mk(1));
        tick();
        chk("wrap_p1", 32'(pop), 32'h2);
        active = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("inact_pop", 32'(pop), 0);
        end
        chk("inact_drain", 32'(pushed - base), 2);
        for (int i = 0; i < 3; i++) q[0].push_back(mk(0));
        active = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("act_len_ok", 32'(pop_log.size() >= 5), 1);
        if (pop_log.size() >= 5)
            for (int i = 0; i < 5; i++)
                chk("act_seq", 32'(pop_log[i]), 32'(e5[i]));

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset  = ($urandom_range(0, 199) == 0);
            active = ($urandom_range(0, 9) != 0);
            af     = ($urandom_range(0, 4) == 0);
            for (int k = 0; k < 4; k++)
                if (q[k].size() < 6 && $urandom_range(0, 2) == 0)
                    q[k].push_back(mk(k));
            tick();
        end
        reset = 1'b0;
        active = 1'b1;
        af = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        for (int k = 0; k < 4; k++) chk("drained", 32'(q[k].size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qos_egress_arbiter.md
Name: qos_egress_arbiter

Overview:
- Egress side of the QoS path: drains the four per-class FIFOs (P0..P3) into the single shared output FIFO.
- The ingress router fills the class FIFOs by class field [11:10]; this block empties them.
- Scheduling is weighted round-robin, with backpressure from the output FIFO almost_full.
- FIFO reads have one-cycle latency; pop/push outputs are registered.

Parameters:
- WORD_W, 12, data word width; class field is [WORD_W-1:WORD_W-2].
- W0, 4, consecutive-grant weight for class 0 (range 1..15).
- W1, 3, weight for class 1.
- W2, 2, weight for class 2.
- W3, 1, weight for class 3.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- active  in  1  enable; 0 = issue no new pops, drain in-flight words.
- empty  in  4  empty flags of class FIFOs, bit k = class k.
- fifo_data0..fifo_data3  in  WORD_W each  class FIFO read data; valid the cycle after the pop.
- almost_full_out  in  1  almost_full of output FIFO.
- pop  out  4  one-hot pop to class FIFOs.
- push  out  1  push to output FIFO.
- data_out  out  WORD_W  word to output FIFO, qualified by push.

Behaviour:
- Reset, sampled on the clk edge with reset=1:
  - pop=0, push=0, data_out=0.
  - cur=0, credit=W0, state=IDLE.
  - In-flight pipeline cleared, so a word popped in the reset cycle is dropped.
- States:
  - IDLE: no pop this cycle.
  - SERVE: a pop was issued this cycle.
  - Each cycle, state goes to SERVE if a grant is made, else IDLE.
- Grant rule, evaluated each cycle when active=1 and almost_full_out=0:
  - If empty[cur]=0 and credit>0: grant cur; credit<=credit-1.
  - Otherwise: grant the first k with empty[k]=0, searching cur+1, cur+2, cur+3 (mod 4). Then cur<=k and credit<=Wk-1.
  - If all four are empty: no grant; cur and credit hold.
- pop[k]=1 for exactly one cycle per grant, registered and driven from the grant decision.
- pop is never asserted when active=0 or almost_full_out=1 or empty[k]=1.
- Pipeline:
  - pop[k] asserted in cycle N, so the FIFO drives fifo_datak in N+1.
  - The block captures it with sel_q=k, giving push=1 and data_out=word in cycle N+2.
  - Latency from pop to push is 2 cycles; throughput is 1 word/cycle.
- Backpressure:
  - almost_full_out=1 stops new grants the same cycle.
  - Words already popped, at most 2 in flight, are still pushed and never dropped.
  - The output FIFO almost_full threshold must leave at least 2 free entries.
- active=0 during traffic: pops stop immediately; in-flight words are pushed on schedule; cur and credit are retained.
- Class switch on empty: if cur empties mid-burst, the next nonempty class is granted in the same cycle, with no idle bubble.
- Weight exhaustion: after Wk consecutive grants, class k yields if any other class is nonempty. If every other class is empty, credit reloads to Wk-1 and k continues.
- Wrap-around: cur=3 searches 0,1,2.
- Simultaneous events are evaluated on the same cycle's inputs: empty[cur] 1->0 together with almost_full_out 1->0 yields a grant that cycle.
- All-zero data words are forwarded like any other word; no filtering.

Decomposition:
- Package qos_pkg:
  - NUM_CLASSES=4, WORD_W=12.
  - Class codes CLS_P0..CLS_P3 = 2'b00..2'b11.
  - State encoding ST_IDLE/ST_SERVE.
- Sub-module rr_pick, combinational:
  - Inputs: 4-bit request, 2-bit start pointer.
  - Outputs: grant index and any_valid; first request at start+1.. wrapping.
  - Instanced once.

Test Plan:
- Reset: hold reset=1 with all FIFOs nonempty and active=1 -> pop=0, push=0, data_out=0 for every cycle of reset. First pop[0] appears in the cycle after reset falls.
- Weighting: classes 0..3 all nonempty, default weights -> pop sequence 0,0,0,0,1,1,1,2,2,3, then repeats. Each push carries that class's word 2 cycles later, in order.
- Empty mid-burst: class 0 holds 2 words, class 2 holds 5, others empty -> pops 0,0,2,2,2,2,2 with no gap. The push stream is 7 contiguous words with class bits 00,00,10x5.
- Backpressure: almost_full_out rises the cycle after a pop -> pops stop that cycle. The 2 in-flight words are still pushed and the total word count is preserved. Pops resume the cycle after almost_full_out=0.
- Wrap and active: cur=3 with class 3 empty and class 1 nonempty -> grant 1. Then active=0 for 3 cycles -> no pop, pending words drained. active=1 -> class 1 resumes with its remaining credit.
